// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and default width for the serial arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ADD_WIDTH = 8;
endpackage

// File: rtl/fa.sv
// fa: 1-bit full adder cell with propagate/generate outputs
module fa (
  output logic f,
  output logic cout,
  output logic p,
  output logic g,
  input  logic x,
  input  logic y,
  input  logic cin
);
  assign p    = x ^ y;
  assign g    = x & y;
  assign f    = p ^ cin;
  assign cout = g | (p & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder using one fa cell, with registered sum/carry/overflow
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, ss_q, ss_d, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic             fa_f, fa_cout, fa_p_unused, fa_g_unused;
  fa u_fa (
    .f(fa_f), .cout(fa_cout), .p(fa_p_unused), .g(fa_g_unused),
    .x(sa_q[0]), .y(sb_q[0]), .cin(carry_q)
  );
  assign ss_d = {fa_f, ss_q[WIDTH-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sa_q    <= a;
          sb_q    <= b;
          carry_q <= cin;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          ss_q    <= ss_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          // carry_q here is the carry into the MSB, so overflow falls out directly
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q   <= ss_d;
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for the 8-bit serial_adder
module tb_serial_adder;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       busy, done, cout, overflow;
  int         n_chk = 0, n_pass = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic ec, input logic eo);
    logic [7:0] ps;
    logic       pc, po, held, both;
    int         lat, nbusy;
    ps = sum; pc = cout; po = overflow; held = 1'b1; both = 1'b0; lat = -1; nbusy = 0;
    @(negedge clk);
    start = 1'b1; a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    nbusy += int'(busy);
    both |= busy & done;
    if (sum !== ps || cout !== pc || overflow !== po) held = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      both |= busy & done;
      if (done) lat = i;
      else begin
        nbusy += int'(busy);
        if (sum !== ps || cout !== pc || overflow !== po) held = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " busy_cycles"}, 64'(nbusy), 64'd8);
    check({tag, " held"}, 64'(held), 64'd1);
    check({tag, " busy_and_done"}, 64'(both), 64'd0);
    check({tag, " sum"}, 64'(sum), 64'(es));
    check({tag, " cout"}, 64'(cout), 64'(ec));
    check({tag, " overflow"}, 64'(overflow), 64'(eo));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    logic [7:0] ea, eb;
    int         acc_k;
    logic       both;
    #2;
    check("reset_outputs", 64'({busy, done, sum, cout, overflow}), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_add("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_add("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_add("pos_ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("neg_ovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // start held high, operands changing every cycle: accepts at edges 0,10,20
    acc_k = 0; both = 1'b0; ea = '0; eb = '0;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      start = 1'b1; cin = 1'b0;
      a = 8'(k * 7 + 3); b = 8'(k * 13 + 1);
      if (k == acc_k) begin ea = a; eb = b; end
      @(posedge clk); #1;
      both |= busy & done;
      check($sformatf("held_start done k=%0d", k), 64'(done), 64'(k == acc_k + 8));
      if (k == acc_k + 8) begin
        check($sformatf("held_start sum k=%0d", k), 64'(sum), 64'(8'(ea + eb)));
        acc_k += 10;
      end
    end
    check("held_start busy_and_done", 64'(both), 64'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset after three bits of a run
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'h01;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset_outputs", 64'({busy, done, sum, cout, overflow}), 64'd0);
    @(negedge clk); rst = 1'b0;
    both = 1'b0;
    repeat (12) begin @(posedge clk); #1; both |= done | busy; end
    check("no_done_after_reset", 64'(both), 64'd0);
    run_add("after_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
